// File: rtl/nanaseg_pkg.sv
// rtl/nanaseg_pkg.sv - shared 7-seg pattern constants and readback FSM states
package nanaseg_pkg;

    // Active-low segment patterns, bit0=a .. bit6=g; shared with the forward decoder.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_ILLEGAL = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } rb_state_t;

endpackage

// File: rtl/nanaseg_encoder.sv
// rtl/nanaseg_encoder.sv - segment pattern to 4-bit code, flags unknown patterns
module nanaseg_encoder
    import nanaseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        code    = CODE_ILLEGAL;
        illegal = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/nanaseg_readback.sv
// rtl/nanaseg_readback.sv - settles a multiplexed 7-seg bus and reads back per-digit codes
module nanaseg_readback
    import nanaseg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [2:0]            upd_digit,
    output logic [3:0]            upd_code,
    output logic                  err_illegal,
    output logic                  err_overrun,
    input  logic                  err_clr
);

    localparam logic [7:0] STABLE_L = 8'(STABLE_CYCLES);

    logic [6:0]        seg_s1, seg_s2, ref_seg;
    logic [DIGITS-1:0] an_s1, an_s2, ref_an;
    logic [7:0]        cnt, cnt_nxt;
    rb_state_t         state, state_nxt;
    logic              load_ref, capture;
    logic              cur_onehot, cur_same;
    logic [3:0]        cap_code;
    logic              cap_illegal;
    logic [2:0]        ref_idx;
    logic              new_digit, ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= SEG_BLANK;
            seg_s2 <= SEG_BLANK;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
        end
    end

    assign cur_onehot = $onehot(~an_s2);
    assign cur_same   = (seg_s2 == ref_seg) && (an_s2 == ref_an);

    nanaseg_encoder u_encoder (
        .seg     (ref_seg),
        .code    (cap_code),
        .illegal (cap_illegal)
    );

    // The capture cycle also inspects the current sample so a pattern change
    // landing exactly on capture starts its own settle without losing a sample.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_ref  = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cur_onehot) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = 8'd1;
                    load_ref  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt >= STABLE_L) begin
                    capture = 1'b1;
                    if (cur_same) begin
                        state_nxt = ST_HELD;
                    end else if (cur_onehot) begin
                        cnt_nxt  = 8'd1;
                        load_ref = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end else if (cur_same) begin
                    cnt_nxt = cnt + 8'd1;
                end else if (cur_onehot) begin
                    cnt_nxt  = 8'd1;
                    load_ref = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            ST_HELD: begin
                if (!cur_same) begin
                    if (cur_onehot) begin
                        state_nxt = ST_SETTLE;
                        cnt_nxt   = 8'd1;
                        load_ref  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            ref_seg <= SEG_BLANK;
            ref_an  <= '1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_ref) begin
                ref_seg <= seg_s2;
                ref_an  <= an_s2;
            end
        end
    end

    always_comb begin
        ref_idx   = 3'd0;
        new_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!ref_an[i]) begin
                ref_idx   = 3'(i);
                new_digit = !digit_valid[i] || (digits_out[4*i +: 4] != cap_code);
            end
        end
    end

    assign ev = capture && new_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_out  <= '1;
            digit_valid <= '0;
        end else if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (!ref_an[i]) begin
                    digit_valid[i] <= 1'b1;
                    if (new_digit)
                        digits_out[4*i +: 4] <= cap_code;
                end
            end
        end
    end

    // Single-entry event slot; a new event may replace one being accepted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid <= 1'b0;
            upd_digit <= 3'd0;
            upd_code  <= 4'd0;
        end else if (ev && (!upd_valid || upd_ready)) begin
            upd_valid <= 1'b1;
            upd_digit <= ref_idx;
            upd_code  <= cap_code;
        end else if (upd_valid && upd_ready) begin
            upd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_illegal <= (capture && cap_illegal) || (err_illegal && !err_clr);
            err_overrun <= (ev && upd_valid && !upd_ready) || (err_overrun && !err_clr);
        end
    end

endmodule

// File: tb/tb_nanaseg_readback.sv
// tb/tb_nanaseg_readback.sv - randomized bench for nanaseg_readback against a run-length model
module tb_nanaseg_readback;

    localparam int D = 4;
    localparam int S = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg_in;
    logic [D-1:0]   an_in;
    logic [4*D-1:0] digits_out;
    logic [D-1:0]   digit_valid;
    logic           upd_valid;
    logic           upd_ready;
    logic [2:0]     upd_digit;
    logic [3:0]     upd_code;
    logic           err_illegal;
    logic           err_overrun;
    logic           err_clr;

    always #5 clk = ~clk;

    nanaseg_readback #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_digit   (upd_digit),
        .upd_code    (upd_code),
        .err_illegal (err_illegal),
        .err_overrun (err_overrun),
        .err_clr     (err_clr)
    );

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int durs [10] = '{1, 2, 3, 6, 7, 8, 9, 10, 14, 20};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model: a digit is captured once its one-hot pattern has been seen for S consecutive cycles.
    logic [3:0]  m_code [D];
    logic [D-1:0] m_valid;
    bit          m_ill, m_ovr;
    logic [6:0]  run_seg;
    logic [D-1:0] run_an;
    int          run_len;
    bit          run_done;
    logic [6:0]  exp_q [$];
    logic [6:0]  mon_q [$];

    function automatic logic [3:0] ref_enc(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (p == seg_tab[i]) return 4'(i);
        if (p == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_code[i] = 4'hF;
        m_valid = '0;
        m_ill = 0;
        m_ovr = 0;
        run_seg = 7'h7F;
        run_an = '1;
        run_len = 0;
        run_done = 0;
        exp_q.delete();
        mon_q.delete();
    endtask

    task automatic model_step();
        int d;
        logic [3:0] c;
        if (seg_in == run_seg && an_in == run_an) begin
            if (run_len < 100000) run_len++;
        end else begin
            run_seg = seg_in;
            run_an = an_in;
            run_len = 1;
            run_done = 0;
        end
        if ($onehot(~an_in) && !run_done && run_len >= S) begin
            run_done = 1;
            d = 0;
            for (int i = 0; i < D; i++) if (!an_in[i]) d = i;
            c = ref_enc(seg_in);
            if (c == 4'hE) m_ill = 1;
            if (!m_valid[d] || m_code[d] != c) begin
                m_code[d] = c;
                m_valid[d] = 1'b1;
                exp_q.push_back({3'(d), c});
            end
        end
    endtask

    always @(posedge clk)
        if (rst_n && upd_valid && upd_ready)
            mon_q.push_back({upd_digit, upd_code});

    task automatic tick();
        @(posedge clk);
        if (err_clr) begin
            m_ill = 0;
            m_ovr = 0;
        end
        model_step();
        #1;
    endtask

    task automatic drive(input logic [6:0] s, input logic [D-1:0] a, input int n);
        seg_in = s;
        an_in = a;
        repeat (n) tick();
    endtask

    task automatic compare_events(input string tag);
        int n;
        chk({tag, "_evcount"}, mon_q.size(), exp_q.size());
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_ev%0d", tag, i), mon_q[i], exp_q[i]);
        mon_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_state(input string tag);
        for (int i = 0; i < D; i++)
            chk($sformatf("%s_digit%0d", tag, i), digits_out[4*i +: 4], m_code[i]);
        chk({tag, "_valid"}, digit_valid, m_valid);
        chk({tag, "_illegal"}, err_illegal, m_ill);
        chk({tag, "_overrun"}, err_overrun, m_ovr);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_digits"}, digits_out, {4*D{1'b1}});
        chk({tag, "_valid"}, digit_valid, 0);
        chk({tag, "_upd_valid"}, upd_valid, 0);
        chk({tag, "_upd_digit"}, upd_digit, 0);
        chk({tag, "_upd_code"}, upd_code, 0);
        chk({tag, "_illegal"}, err_illegal, 0);
        chk({tag, "_overrun"}, err_overrun, 0);
    endtask

    initial begin
        int n, first, r;
        logic [6:0] s;
        logic [D-1:0] a;

        seg_in = 7'h7F;
        an_in = '1;
        upd_ready = 0;
        err_clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1;

        // Single digit settle and event latency
        seg_in = 7'b0110000;
        an_in = 4'b1110;
        n = 0;
        first = 0;
        repeat (12) begin
            tick();
            n++;
            if (upd_valid && first == 0) first = n;
        end
        chk("t1_latency", first, 2 + S + 1);
        chk("t1_digit0", digits_out[3:0], 4'd3);
        chk("t1_valid", digit_valid, 4'b0001);
        chk("t1_upd_digit", upd_digit, 0);
        chk("t1_upd_code", upd_code, 3);
        upd_ready = 1;
        tick();
        upd_ready = 0;
        chk("t1_accepted", upd_valid, 0);
        compare_events("t1");

        // Four-digit scan, then an unchanged second round
        upd_ready = 1;
        for (int d = 0; d < D; d++) drive(seg_tab[d+1], ~(4'b1 << d), 20);
        chk("t2_events", mon_q.size(), 4);
        compare_events("t2a");
        chk("t2_digits", digits_out, 16'h4321);
        for (int d = 0; d < D; d++) drive(seg_tab[d+1], ~(4'b1 << d), 20);
        chk("t2_round2_events", mon_q.size(), 0);
        compare_events("t2b");

        // Glitching pattern never settles
        repeat (5) begin
            drive(seg_tab[7], 4'b1101, 3);
            drive(seg_tab[8], 4'b1101, 3);
        end
        drive(7'h7F, 4'b1111, 15);
        chk("t3_events", mon_q.size(), 0);
        chk("t3_digits", digits_out, 16'h4321);
        compare_events("t3");
        compare_state("t3");

        // Illegal pattern, error clear, blank
        drive(7'b1010101, 4'b1011, 20);
        chk("t4_code_e", digits_out[11:8], 4'hE);
        chk("t4_illegal_set", err_illegal, 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("t4_illegal_clr", err_illegal, 0);
        drive(7'h7F, 4'b1011, 20);
        chk("t4_code_f", digits_out[11:8], 4'hF);
        chk("t4_blank_noerr", err_illegal, 0);
        compare_events("t4");
        compare_state("t4");

        // Overrun while consumer stalls; the second event is dropped
        upd_ready = 0;
        drive(seg_tab[5], 4'b1110, 20);
        drive(seg_tab[6], 4'b1101, 20);
        chk("t5_held_valid", upd_valid, 1);
        chk("t5_held_digit", upd_digit, 0);
        chk("t5_held_code", upd_code, 5);
        chk("t5_overrun", err_overrun, 1);
        m_ovr = 1;
        upd_ready = 1;
        tick();
        upd_ready = 0;
        chk("t5_drained", upd_valid, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        compare_events("t5");
        compare_state("t5");
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("t5_overrun_clr", err_overrun, 0);

        // Non-one-hot anodes never capture; reset mid-settle
        upd_ready = 1;
        drive(seg_tab[8], 4'b1100, 50);
        drive(seg_tab[8], 4'b1111, 50);
        chk("t6_events", mon_q.size(), 0);
        compare_state("t6");
        drive(seg_tab[9], 4'b1101, 6);
        rst_n = 0;
        #2;
        check_reset("t6_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();

        // Randomized runs
        repeat (200) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = D'($urandom);
            else a = ~(4'b1 << $urandom_range(0, D-1));
            r = $urandom_range(0, 9);
            if (r < 7) s = seg_tab[$urandom_range(0, 9)];
            else if (r == 7) s = 7'h7F;
            else s = 7'($urandom);
            drive(s, a, durs[$urandom_range(0, 9)]);
        end
        drive(7'h7F, 4'b1111, 15);
        compare_events("rand");
        compare_state("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
